alu_submodule_add_serial: RTL and testbench

- Multi-cycle slice-serial 16-bit adder for the ALU submodule set; the forward-arithmetic counterpart to the combinational subtract submodule.
- Processes operands SLICE_W bits per cycle under a start/done handshake, trading latency for area.
- Reports Answer, carry-out and signed overflow.
- Sits beside the other ALU submodules and is driven by the ALU sequencer.

---
 rtl/alu_submodule_add_serial.sv | 121 ++++++++++++
 tb/tb_alu_submodule_add_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_submodule_add_serial.sv
// Slice-serial adder: adds SLICE_W bits per cycle under a start/done handshake.
// Define ALU_SERIAL_SUB_EN to add a 'sub' input that turns the operation into A - B.
module alu_submodule_add_serial #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_SERIAL_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Answer,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NS = WIDTH / SLICE_W;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    generate
        if ((SLICE_W < 1) || (WIDTH % SLICE_W != 0)) begin : g_bad_slice
            $error("alu_submodule_add_serial: SLICE_W must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_res;
    logic                 r_carry;
    logic [CW-1:0]        r_cnt;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_b_cap;
    logic                 w_c0;
    logic [SLICE_W:0]     w_slice;
    logic                 w_c_msb;
    logic [WIDTH+SLICE_W-1:0] w_cat;
    logic [WIDTH-1:0]     w_res_next;

`ifdef ALU_SERIAL_SUB_EN
    // Subtraction as A + ~B + 1: invert at capture, seed the carry with 1.
    assign w_b_cap = sub ? ~B : B;
    assign w_c0    = sub;
`else
    assign w_b_cap = B;
    assign w_c0    = 1'b0;
`endif

    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign w_accept = start && ready;
    assign w_last   = (r_cnt == CW'(NS - 1));

    // Operands shift right so the active slice always sits in the low bits.
    assign w_slice = {1'b0, r_a[SLICE_W-1:0]} + {1'b0, r_b[SLICE_W-1:0]}
                   + {{SLICE_W{1'b0}}, r_carry};
    // Carry into the slice MSB, recovered from its sum bit and operand bits.
    assign w_c_msb    = w_slice[SLICE_W-1] ^ r_a[SLICE_W-1] ^ r_b[SLICE_W-1];
    assign w_cat      = {w_slice[SLICE_W-1:0], r_res};
    assign w_res_next = w_cat[WIDTH+SLICE_W-1:SLICE_W];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            Answer    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_cap;
            r_carry <= w_c0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> SLICE_W;
            r_b     <= r_b >> SLICE_W;
            r_carry <= w_slice[SLICE_W];
            r_res   <= w_res_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                Answer    <= w_res_next;
                carry_out <= w_slice[SLICE_W];
                overflow  <= w_c_msb ^ w_slice[SLICE_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_submodule_add_serial.sv
// Directed bench for alu_submodule_add_serial (default 16-bit, 4-bit slices).
module tb_alu_submodule_add_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] Answer;
    logic        carry_out;
    logic        overflow;
`ifdef ALU_SERIAL_SUB_EN
    logic        sub;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_submodule_add_serial #(.WIDTH(16), .SLICE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ALU_SERIAL_SUB_EN
        .sub       (sub),
`endif
        .start     (start),
        .A         (A),
        .B         (B),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .Answer    (Answer),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation from a ready state; checks timing, handshake and result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] ea, input logic ec, input logic ev);
        int cyc;
        int nbusy;
        A = a;
        B = b;
`ifdef ALU_SERIAL_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub requested without ALU_SERIAL_SUB_EN");
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        A = ~a;
        cyc = 1;
        nbusy = 0;
        while (!done && cyc < 20) begin
            if (busy) begin
                nbusy++;
                check({tag, "_ready_run"}, ready, 0);
            end
            step();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 5);
        check({tag, "_busy_cycles"}, nbusy, 4);
        check({tag, "_ans"}, Answer, ea);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, ev);
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_after"}, ready, 1);
        check({tag, "_ans_hold"}, Answer, ea);
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
`ifdef ALU_SERIAL_SUB_EN
        sub = 1'b0;
`endif
        step();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ans", Answer, 0);
        check("rst_flags", {carry_out, overflow}, 0);

        // start already high while reset releases: accepted at first clean edge
        A = 16'd4;
        B = 16'd4;
        start = 1'b1;
        #2 rst = 1'b0;
        step();
        start = 1'b0;
        check("rstrel_busy", busy, 1);
        step(); step(); step(); step();
        check("rstrel_done", done, 1);
        check("rstrel_ans", Answer, 8);
        step();

        run_op("add15_10", 16'd15, 16'd10, 1'b0, 16'd25, 1'b0, 1'b0);
        run_op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("a5a5_5a5b", 16'hA5A5, 16'h5A5B, 1'b0, 16'h0000, 1'b1, 1'b0);

        // start during RUN ignored, operand change after capture ignored
        A = 16'd13; B = 16'd13; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 16'd1; B = 16'd1; start = 1'b1;
        step();
        start = 1'b0; A = 16'hFFFF;
        step(); step();
        check("ign_done", done, 1);
        check("ign_ans", Answer, 26);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) ndone++;
        end
        check("ign_single_done", ndone, 0);
        check("ign_hold", Answer, 26);

        // back-to-back: start accepted in the DONE cycle
        A = 16'd1; B = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check("b2b_first_done", done, 1);
        check("b2b_first_ans", Answer, 3);
        A = 16'd100; B = 16'd200; start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_no_idle", busy, 1);
        check("b2b_hold0", Answer, 3);
        step(); step(); step();
        check("b2b_not_yet", done, 0);
        check("b2b_hold3", Answer, 3);
        step();
        check("b2b_done", done, 1);
        check("b2b_ans", Answer, 300);
        step();

        // asynchronous reset during the second RUN cycle
        A = 16'd7; B = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 1);
        check("arst_done", done, 0);
        check("arst_ans", Answer, 0);
        check("arst_flags", {carry_out, overflow}, 0);
        step();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) ndone++;
        end
        check("arst_no_done", ndone, 0);
        run_op("post_rst", 16'd2, 16'd3, 1'b0, 16'd5, 1'b0, 1'b0);

`ifdef ALU_SERIAL_SUB_EN
        run_op("sub5_8", 16'd5, 16'd8, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        run_op("sub15_10", 16'd15, 16'd10, 1'b1, 16'd5, 1'b1, 1'b0);
        run_op("sub8000_1", 16'h8000, 16'd1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
